hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / memory-wait stalls, branch/trap flushes.
// Latency: forwarding and stall/flush outputs are combinational (zero cycles); state and counter update on clk_i.
// Backpressure: mem_busy_i holds every stage; a load-use hazard holds IF/ID for one cycle and bubbles EX.
//
// Ports:
//   clk_i, rst_i                        clock (rising edge), asynchronous active-high reset
//   id_rs1_i/id_rs2_i, id_use_rs*_i     sources read by the instruction in ID
//   ex_/mem_/wb_ rd, we, dat            destinations and results of the later stages (ex_is_ld_i marks a load)
//   mem_busy_i, br_taken_i, trap_i      hazard events
//   is_fwd_*_o, dat_fwd_*_o             forwarding select and data for the ID operand muxes
//   stall_*_o, flush_*_o                hold / bubble controls per stage register
//   stall_cnt_o                         saturating count of cycles with any stall asserted
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_we_i,
   input  logic             ex_is_ld_i,
   input  logic [31:0]      ex_dat_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_we_i,
   input  logic [31:0]      mem_dat_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             wb_we_i,
   input  logic [31:0]      wb_dat_i,
   input  logic             mem_busy_i,
   input  logic             br_taken_i,
   input  logic             trap_i,
   output logic             is_fwd_a_o,
   output logic             is_fwd_b_o,
   output logic [31:0]      dat_fwd_a_o,
   output logic [31:0]      dat_fwd_b_o,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             stall_ex_o,
   output logic             stall_mem_o,
   output logic             flush_id_o,
   output logic             flush_ex_o,
   output logic             flush_mem_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_LD_STALL = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;
   localparam logic [1:0] S_FLUSH    = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       ex_fwd_ok;
   logic       load_use;
   logic       any_stall;

   // A load's EX result is an address, not data, so EX never forwards for loads.
   assign ex_fwd_ok = ex_we_i & ~ex_is_ld_i;

   always_comb begin
      is_fwd_a_o  = 1'b0;
      dat_fwd_a_o = '0;
      if (id_use_rs1_i && id_rs1_i != 5'd0) begin
         if (ex_fwd_ok && ex_rd_i == id_rs1_i) begin
            is_fwd_a_o  = 1'b1;
            dat_fwd_a_o = ex_dat_i;
         end else if (mem_we_i && mem_rd_i == id_rs1_i) begin
            is_fwd_a_o  = 1'b1;
            dat_fwd_a_o = mem_dat_i;
         end else if (wb_we_i && wb_rd_i == id_rs1_i) begin
            is_fwd_a_o  = 1'b1;
            dat_fwd_a_o = wb_dat_i;
         end
      end
   end

   always_comb begin
      is_fwd_b_o  = 1'b0;
      dat_fwd_b_o = '0;
      if (id_use_rs2_i && id_rs2_i != 5'd0) begin
         if (ex_fwd_ok && ex_rd_i == id_rs2_i) begin
            is_fwd_b_o  = 1'b1;
            dat_fwd_b_o = ex_dat_i;
         end else if (mem_we_i && mem_rd_i == id_rs2_i) begin
            is_fwd_b_o  = 1'b1;
            dat_fwd_b_o = mem_dat_i;
         end else if (wb_we_i && wb_rd_i == id_rs2_i) begin
            is_fwd_b_o  = 1'b1;
            dat_fwd_b_o = wb_dat_i;
         end
      end
   end

   assign load_use = ex_is_ld_i & ex_we_i & (ex_rd_i != 5'd0) &
                     ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                      (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

   // Event priority: memory wait > trap > branch > load-use.
   // Load-use is only acted on from RUN or on leaving MEM_WAIT; in LD_STALL the
   // load has already moved on, and in FLUSH the ID instruction is being killed.
   always_comb begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_ex_o  = 1'b0;
      stall_mem_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      flush_mem_o = 1'b0;
      state_nxt   = S_RUN;
      if (mem_busy_i) begin
         stall_if_o  = 1'b1;
         stall_id_o  = 1'b1;
         stall_ex_o  = 1'b1;
         stall_mem_o = 1'b1;
         state_nxt   = S_MEM_WAIT;
      end else if (trap_i) begin
         flush_id_o  = 1'b1;
         flush_ex_o  = 1'b1;
         flush_mem_o = 1'b1;
         state_nxt   = S_FLUSH;
      end else if (br_taken_i) begin
         flush_id_o  = 1'b1;
         flush_ex_o  = 1'b1;
      end else if (load_use && (state == S_RUN || state == S_MEM_WAIT)) begin
         stall_if_o  = 1'b1;
         stall_id_o  = 1'b1;
         flush_ex_o  = 1'b1;
         state_nxt   = S_LD_STALL;
      end else if (state == S_FLUSH) begin
         // Second cycle of a trap: the instruction fetched behind the trap is dropped.
         flush_id_o  = 1'b1;
      end
      // Outputs stay quiet for the whole time reset is held, not just after the edge.
      if (rst_i) begin
         stall_if_o  = 1'b0;
         stall_id_o  = 1'b0;
         stall_ex_o  = 1'b0;
         stall_mem_o = 1'b0;
         flush_id_o  = 1'b0;
         flush_ex_o  = 1'b0;
         flush_mem_o = 1'b0;
      end
   end

   assign any_stall = stall_if_o | stall_id_o | stall_ex_o | stall_mem_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_RUN;
         stall_cnt_o <= '0;
      end else begin
         state <= state_nxt;
         if (any_stall && stall_cnt_o != {CNT_W{1'b1}})
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic        use1, use2, ex_we, ex_is_ld, mem_we, wb_we;
   logic [31:0] ex_dat, mem_dat, wb_dat;
   logic        mem_busy, br_taken, trap;

   logic        fa, fb, fa4, fb4;
   logic [31:0] da, db, da4, db4;
   logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem;
   logic        s_if4, s_id4, s_ex4, s_mem4, f_id4, f_ex4, f_mem4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   wire [6:0] ctl  = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem};
   wire [6:0] ctl4 = {s_if4, s_id4, s_ex4, s_mem4, f_id4, f_ex4, f_mem4};

   int n_pass = 0;
   int n_total = 0;

   // Reference model state: which phase the controller is in.
   localparam int M_RUN = 0, M_LD = 1, M_WAIT = 2, M_FL = 3;
   int          m_state;
   logic [15:0] m_cnt;
   logic [3:0]  m_cnt4;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .ex_rd_i(ex_rd), .ex_we_i(ex_we), .ex_is_ld_i(ex_is_ld), .ex_dat_i(ex_dat),
      .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_dat_i(mem_dat),
      .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_dat_i(wb_dat),
      .mem_busy_i(mem_busy), .br_taken_i(br_taken), .trap_i(trap),
      .is_fwd_a_o(fa), .is_fwd_b_o(fb), .dat_fwd_a_o(da), .dat_fwd_b_o(db),
      .stall_if_o(s_if), .stall_id_o(s_id), .stall_ex_o(s_ex), .stall_mem_o(s_mem),
      .flush_id_o(f_id), .flush_ex_o(f_ex), .flush_mem_o(f_mem),
      .stall_cnt_o(cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .ex_rd_i(ex_rd), .ex_we_i(ex_we), .ex_is_ld_i(ex_is_ld), .ex_dat_i(ex_dat),
      .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_dat_i(mem_dat),
      .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_dat_i(wb_dat),
      .mem_busy_i(mem_busy), .br_taken_i(br_taken), .trap_i(trap),
      .is_fwd_a_o(fa4), .is_fwd_b_o(fb4), .dat_fwd_a_o(da4), .dat_fwd_b_o(db4),
      .stall_if_o(s_if4), .stall_id_o(s_id4), .stall_ex_o(s_ex4), .stall_mem_o(s_mem4),
      .flush_id_o(f_id4), .flush_ex_o(f_ex4), .flush_mem_o(f_mem4),
      .stall_cnt_o(cnt4)
   );

   // ---------------- reference model ----------------
   // Forwarding: walk the producers from youngest to oldest, first eligible match wins.
   function automatic logic [32:0] exp_fwd(input logic u, input logic [4:0] rs);
      logic [4:0]  rd [3];
      logic        ok [3];
      logic [31:0] d  [3];
      rd[0] = ex_rd;  ok[0] = ex_we && !ex_is_ld; d[0] = ex_dat;
      rd[1] = mem_rd; ok[1] = mem_we;             d[1] = mem_dat;
      rd[2] = wb_rd;  ok[2] = wb_we;              d[2] = wb_dat;
      if (!u || rs == 5'd0) return 33'd0;
      for (int i = 0; i < 3; i++)
         if (ok[i] && rd[i] == rs) return {1'b1, d[i]};
      return 33'd0;
   endfunction

   // Control vector {stall if,id,ex,mem, flush id,ex,mem} and next phase.
   function automatic void model_step(input int st, output logic [6:0] c, output int nx);
      logic lu;
      lu = ex_is_ld && ex_we && ex_rd != 0 &&
           ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
      if (rst)                                     begin c = 7'b0000_000; nx = M_RUN;  end
      else if (mem_busy)                           begin c = 7'b1111_000; nx = M_WAIT; end
      else if (trap)                               begin c = 7'b0000_111; nx = M_FL;   end
      else if (br_taken)                           begin c = 7'b0000_110; nx = M_RUN;  end
      else if (lu && (st == M_RUN || st == M_WAIT)) begin c = 7'b1100_010; nx = M_LD;   end
      else if (st == M_FL)                         begin c = 7'b0000_100; nx = M_RUN;  end
      else                                         begin c = 7'b0000_000; nx = M_RUN;  end
   endfunction

   task automatic advance();
      logic [6:0] c;
      int nx;
      model_step(m_state, c, nx);
      @(posedge clk);
      if (!rst) begin
         m_state = nx;
         if (|c[6:3]) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      id_rs1 = 0; id_rs2 = 0; use1 = 0; use2 = 0;
      ex_rd = 0; ex_we = 0; ex_is_ld = 0; ex_dat = 0;
      mem_rd = 0; mem_we = 0; mem_dat = 0;
      wb_rd = 0; wb_we = 0; wb_dat = 0;
      mem_busy = 0; br_taken = 0; trap = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
      m_state = M_RUN; m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic set_load_use();
      ex_is_ld = 1; ex_we = 1; ex_rd = 5'd3; ex_dat = 32'h1000;
      id_rs2 = 5'd3; use2 = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      mem_busy = 1; trap = 1;
      #2;
      n_total++; if (ctl !== 7'd0) $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'd0); else n_pass++;
      n_total++; if (cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else n_pass++;
      n_total++; if (cnt4 !== 4'd0) $display("FAIL reset_cnt4 got=%0d exp=0", cnt4); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (cnt !== 16'd0) $display("FAIL reset_cnt_hold got=%0d exp=0", cnt); else n_pass++;
      clear_inputs();
      rst = 1'b0;
      m_state = M_RUN; m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic test_forward();
      logic [32:0] ea, eb;
      clear_inputs();
      id_rs1 = 5; use1 = 1;
      ex_rd = 5; ex_we = 1; ex_dat = 32'h11;
      mem_rd = 5; mem_we = 1; mem_dat = 32'h22;
      #2;
      n_total++; if ({fa, da} !== {1'b1, 32'h11}) $display("FAIL fwd_ex got=%b/%h exp=1/11", fa, da); else n_pass++;
      ex_we = 0; #2;
      n_total++; if ({fa, da} !== {1'b1, 32'h22}) $display("FAIL fwd_mem got=%b/%h exp=1/22", fa, da); else n_pass++;
      mem_we = 0; wb_rd = 5; wb_we = 1; wb_dat = 32'h33; #2;
      n_total++; if ({fa, da} !== {1'b1, 32'h33}) $display("FAIL fwd_wb got=%b/%h exp=1/33", fa, da); else n_pass++;
      id_rs1 = 0; #2;
      n_total++; if ({fa, da} !== 33'd0) $display("FAIL fwd_r0 got=%b/%h exp=0/0", fa, da); else n_pass++;
      id_rs2 = 5; use2 = 0; #2;
      n_total++; if ({fb, db} !== 33'd0) $display("FAIL fwd_b_unused got=%b/%h exp=0/0", fb, db); else n_pass++;
      use2 = 1; #2;
      n_total++; if ({fb, db} !== {1'b1, 32'h33}) $display("FAIL fwd_b_wb got=%b/%h exp=1/33", fb, db); else n_pass++;
      for (int i = 0; i < 300; i++) begin
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         use1 = 1'($urandom); use2 = 1'($urandom);
         ex_rd = 5'($urandom_range(0, 3)); ex_we = 1'($urandom); ex_is_ld = 1'($urandom); ex_dat = $urandom;
         mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom); mem_dat = $urandom;
         wb_rd = 5'($urandom_range(0, 3)); wb_we = 1'($urandom); wb_dat = $urandom;
         #2;
         ea = exp_fwd(use1, id_rs1);
         eb = exp_fwd(use2, id_rs2);
         n_total++; if ({fa, da} !== ea) $display("FAIL fwd_rand_a got=%b/%h exp=%b/%h", fa, da, ea[32], ea[31:0]); else n_pass++;
         n_total++; if ({fb, db} !== eb) $display("FAIL fwd_rand_b got=%b/%h exp=%b/%h", fb, db, eb[32], eb[31:0]); else n_pass++;
         n_total++; if ({fa4, da4, fb4, db4} !== {ea, eb}) $display("FAIL fwd_rand_w4 got=%b/%h exp=%b/%h", fa4, da4, ea[32], ea[31:0]); else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #2;
      n_total++; if (ctl !== 7'b1100_010) $display("FAIL lu_cycle0 got=%b exp=%b", ctl, 7'b1100_010); else n_pass++;
      advance();
      #2;
      n_total++; if (ctl !== 7'b0000_000) $display("FAIL lu_cycle1 got=%b exp=%b", ctl, 7'b0000_000); else n_pass++;
      n_total++; if (cnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", cnt); else n_pass++;
      advance();
      #2;
      // Back in RUN: the same hazard stalls again.
      n_total++; if (ctl !== 7'b1100_010) $display("FAIL lu_back_in_run got=%b exp=%b", ctl, 7'b1100_010); else n_pass++;
      ex_is_ld = 0; ex_we = 0; mem_rd = 3; mem_we = 1; mem_dat = 32'hABCD; #2;
      n_total++; if ({ctl, fb, db} !== {7'd0, 1'b1, 32'hABCD}) $display("FAIL lu_mem_fwd got=%b/%b/%h exp=0/1/abcd", ctl, fb, db); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_load_use();
      mem_busy = 1;
      for (int i = 0; i < 4; i++) begin
         #2;
         n_total++; if (ctl !== 7'b1111_000) $display("FAIL mw_cycle%0d got=%b exp=%b", i, ctl, 7'b1111_000); else n_pass++;
         advance();
      end
      mem_busy = 0; #2;
      n_total++; if (cnt !== 16'd4) $display("FAIL mw_cnt got=%0d exp=4", cnt); else n_pass++;
      n_total++; if (ctl !== 7'b1100_010) $display("FAIL mw_then_lu got=%b exp=%b", ctl, 7'b1100_010); else n_pass++;
      advance();
      n_total++; if (cnt !== 16'd5) $display("FAIL mw_cnt_after_lu got=%0d exp=5", cnt); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_trap_branch();
      do_reset();
      trap = 1; br_taken = 1; #2;
      n_total++; if (ctl !== 7'b0000_111) $display("FAIL trap_c0 got=%b exp=%b", ctl, 7'b0000_111); else n_pass++;
      advance();
      trap = 0; br_taken = 0; #2;
      n_total++; if (ctl !== 7'b0000_100) $display("FAIL trap_c1 got=%b exp=%b", ctl, 7'b0000_100); else n_pass++;
      advance(); #2;
      n_total++; if (ctl !== 7'b0000_000) $display("FAIL trap_c2 got=%b exp=%b", ctl, 7'b0000_000); else n_pass++;
      set_load_use(); br_taken = 1; #2;
      n_total++; if (ctl !== 7'b0000_110) $display("FAIL br_over_lu got=%b exp=%b", ctl, 7'b0000_110); else n_pass++;
      advance();
      clear_inputs(); #2;
      n_total++; if (ctl !== 7'b0000_000) $display("FAIL br_after got=%b exp=%b", ctl, 7'b0000_000); else n_pass++;
      n_total++; if (cnt !== 16'd0) $display("FAIL br_cnt got=%0d exp=0", cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_load_use();
      advance();
      mem_busy = 1; #2;
      n_total++; if (ctl !== 7'b1111_000) $display("FAIL rms_pre got=%b exp=%b", ctl, 7'b1111_000); else n_pass++;
      rst = 1; #1;
      n_total++; if (ctl !== 7'd0) $display("FAIL rms_ctl got=%b exp=0", ctl); else n_pass++;
      n_total++; if (cnt !== 16'd0) $display("FAIL rms_cnt got=%0d exp=0", cnt); else n_pass++;
      @(posedge clk); #1;
      rst = 0; m_state = M_RUN; m_cnt = 0; m_cnt4 = 0;
      clear_inputs(); #2;
      n_total++; if (ctl !== 7'd0) $display("FAIL rms_release got=%b exp=0", ctl); else n_pass++;
      advance();
      n_total++; if (cnt !== 16'd0) $display("FAIL rms_cnt_after got=%0d exp=0", cnt); else n_pass++;
      set_load_use(); #2;
      n_total++; if (ctl !== 7'b1100_010) $display("FAIL rms_run_state got=%b exp=%b", ctl, 7'b1100_010); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      mem_busy = 1;
      for (int i = 0; i < 20; i++) begin
         #2;
         n_total++; if (ctl4 !== 7'b1111_000) $display("FAIL sat_ctl4 got=%b exp=%b", ctl4, 7'b1111_000); else n_pass++;
         advance();
      end
      mem_busy = 0; #2;
      n_total++; if (cnt4 !== 4'd15) $display("FAIL sat_cnt4 got=%0d exp=15", cnt4); else n_pass++;
      n_total++; if (cnt !== 16'd20) $display("FAIL sat_cnt16 got=%0d exp=20", cnt); else n_pass++;
      advance();
      n_total++; if (cnt4 !== 4'd15) $display("FAIL sat_cnt4_hold got=%0d exp=15", cnt4); else n_pass++;
   endtask

   task automatic test_random();
      logic [6:0]  c;
      int          nx;
      logic [32:0] ea, eb;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         use1 = 1'($urandom); use2 = 1'($urandom);
         ex_rd = 5'($urandom_range(0, 3)); ex_we = 1'($urandom);
         ex_is_ld = ($urandom_range(0, 2) == 0); ex_dat = $urandom;
         mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom); mem_dat = $urandom;
         wb_rd = 5'($urandom_range(0, 3)); wb_we = 1'($urandom); wb_dat = $urandom;
         mem_busy = ($urandom_range(0, 7) == 0);
         trap = ($urandom_range(0, 15) == 0);
         br_taken = ($urandom_range(0, 7) == 0);
         #2;
         model_step(m_state, c, nx);
         ea = exp_fwd(use1, id_rs1);
         eb = exp_fwd(use2, id_rs2);
         n_total++; if (ctl !== c) $display("FAIL rand_ctl it=%0d got=%b exp=%b", i, ctl, c); else n_pass++;
         n_total++; if (ctl4 !== c) $display("FAIL rand_ctl4 it=%0d got=%b exp=%b", i, ctl4, c); else n_pass++;
         n_total++; if ({fa, da, fb, db} !== {ea, eb}) $display("FAIL rand_fwd it=%0d got=%b/%h,%b/%h exp=%b/%h,%b/%h", i, fa, da, fb, db, ea[32], ea[31:0], eb[32], eb[31:0]); else n_pass++;
         n_total++; if (cnt !== m_cnt) $display("FAIL rand_cnt it=%0d got=%0d exp=%0d", i, cnt, m_cnt); else n_pass++;
         n_total++; if (cnt4 !== m_cnt4) $display("FAIL rand_cnt4 it=%0d got=%0d exp=%0d", i, cnt4, m_cnt4); else n_pass++;
         advance();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      m_state = M_RUN; m_cnt = 0; m_cnt4 = 0;
      test_reset();
      test_forward();
      test_load_use();
      test_mem_wait();
      test_trap_branch();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
